digital_clock_tk: RTL and testbench

Parametrised time-of-day counter, the successor to the fixed 1 Hz clock block. It runs from the system clock through an internal seconds prescaler and loads time through a valid/ready handshake that rejects invalid values. It provides 24 h binary and 12/24 h BCD display outputs, plus a `day_tick` carry pulse that drives the calendar module. An hh:mm alarm comparator can be compiled in.

---
 rtl/digital_clock_tk_if.sv | 22 ++
 rtl/digital_clock_tk.sv | 172 +++++++++++++++++
 tb/tb_digital_clock_tk.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/digital_clock_tk_if.sv
// Load/alarm handshake bundle for digital_clock_tk.
// The master is the time source or controller; the slave is the clock core.
interface digital_clock_tk_if;
  logic        load_valid;
  logic        load_ready;
  logic [16:0] load_time;
  logic        load_err;
  logic        alarm_valid;
  logic [10:0] alarm_time;
  logic        alarm_on;
  logic        alarm_fire;

  modport master (
    output load_valid, load_time, alarm_valid, alarm_time, alarm_on,
    input  load_ready, load_err, alarm_fire
  );

  modport slave (
    input  load_valid, load_time, alarm_valid, alarm_time, alarm_on,
    output load_ready, load_err, alarm_fire
  );
endinterface

// File: rtl/digital_clock_tk.sv
// Time-of-day counter with seconds prescaler, validated load handshake and
// binary/BCD outputs; alarm comparator compiled in with DIGITAL_CLOCK_ALARM_EN.
module digital_clock_tk #(
  parameter int TICK_DIV  = 1,
  parameter int INIT_HOUR = 0,
  parameter int INIT_MIN  = 0,
  parameter int INIT_SEC  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               mode_12h,
  digital_clock_tk_if.slave  bus,
  output logic [4:0]         hour_out,
  output logic [5:0]         min_out,
  output logic [5:0]         sec_out,
  output logic               pm,
  output logic [3:0]         sec_1s,
  output logic [3:0]         sec_10s,
  output logic [3:0]         min_1s,
  output logic [3:0]         min_10s,
  output logic [3:0]         hr_1s,
  output logic [3:0]         hr_10s,
  output logic               sec_tick,
  output logic               day_tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic            sec_tick_q, sec_tick_d;
  logic            day_tick_q, day_tick_d;
  logic            load_err_q, load_err_d;

  logic            tick, xfer, ld_ok, adv;
  logic            sec_wrap, min_wrap, hour_wrap;
  logic [4:0]      ld_hour;
  logic [5:0]      ld_min, ld_sec;
  logic            alarm_err;
  logic [4:0]      hr_disp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      hour_q     <= 5'(INIT_HOUR);
      min_q      <= 6'(INIT_MIN);
      sec_q      <= 6'(INIT_SEC);
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
      load_err_q <= load_err_d;
    end
  end

  // A handshake in the same cycle as a tick swallows that tick.
  always_comb begin
    ld_hour   = bus.load_time[16:12];
    ld_min    = bus.load_time[11:6];
    ld_sec    = bus.load_time[5:0];
    ld_ok     = (ld_hour <= 5'd23) && (ld_min <= 6'd59) && (ld_sec <= 6'd59);
    xfer      = bus.load_valid && (state_q == IDLE);
    tick      = run && (pcnt_q == PW'(TICK_DIV - 1));
    adv       = tick && !xfer;
    sec_wrap  = (sec_q == 6'd59);
    min_wrap  = (min_q == 6'd59);
    hour_wrap = (hour_q == 5'd23);

    state_d    = state_q;
    pcnt_d     = pcnt_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_tick_d = 1'b0;
    load_err_d = alarm_err;

    case (state_q)
      IDLE:    if (bus.load_valid) state_d = BUSY;
      BUSY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (tick)      pcnt_d = '0;
    else if (run)  pcnt_d = pcnt_q + PW'(1);

    if (xfer && ld_ok) begin
      hour_d = ld_hour;
      min_d  = ld_min;
      sec_d  = ld_sec;
      pcnt_d = '0;
    end else if (xfer) begin
      load_err_d = 1'b1;
    end else if (adv) begin
      sec_tick_d = 1'b1;
      sec_d      = sec_wrap ? 6'd0 : sec_q + 6'd1;
      if (sec_wrap) min_d = min_wrap ? 6'd0 : min_q + 6'd1;
      if (sec_wrap && min_wrap) hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
      day_tick_d = sec_wrap && min_wrap && hour_wrap;
    end
  end

`ifdef DIGITAL_CLOCK_ALARM_EN
  logic [10:0] alarm_q, alarm_d;
  logic        alarm_fire_q, alarm_fire_d;
  logic        alarm_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q      <= '0;
      alarm_fire_q <= 1'b0;
    end else begin
      alarm_q      <= alarm_d;
      alarm_fire_q <= alarm_fire_d;
    end
  end

  // Only a tick can fire the alarm, so loading onto the alarm time stays silent.
  always_comb begin
    alarm_ok     = (bus.alarm_time[10:6] <= 5'd23) && (bus.alarm_time[5:0] <= 6'd59);
    alarm_d      = alarm_q;
    alarm_err    = bus.alarm_valid && !alarm_ok;
    if (bus.alarm_valid && alarm_ok) alarm_d = bus.alarm_time;
    alarm_fire_d = adv && bus.alarm_on && (sec_d == 6'd0) && ({hour_d, min_d} == alarm_q);
  end

  assign bus.alarm_fire = alarm_fire_q;
`else
  logic unused_alarm;
  assign unused_alarm   = ^{bus.alarm_valid, bus.alarm_time, bus.alarm_on};
  assign alarm_err      = 1'b0;
  assign bus.alarm_fire = 1'b0;
`endif

  always_comb begin
    hr_disp = hour_q;
    if (mode_12h) begin
      if (hour_q == 5'd0)       hr_disp = 5'd12;
      else if (hour_q > 5'd12)  hr_disp = hour_q - 5'd12;
    end
    sec_1s  = 4'(sec_q % 6'd10);
    sec_10s = 4'(sec_q / 6'd10);
    min_1s  = 4'(min_q % 6'd10);
    min_10s = 4'(min_q / 6'd10);
    hr_1s   = 4'(hr_disp % 5'd10);
    hr_10s  = 4'(hr_disp / 5'd10);
  end

  assign hour_out       = hour_q;
  assign min_out        = min_q;
  assign sec_out        = sec_q;
  assign pm             = (hour_q >= 5'd12);
  assign sec_tick       = sec_tick_q;
  assign day_tick       = day_tick_q;
  assign bus.load_err   = load_err_q;
  assign bus.load_ready = (state_q == IDLE);

endmodule

// File: tb/tb_digital_clock_tk.sv
// Directed bench for digital_clock_tk (TICK_DIV=4, reset time 23:59:58);
// alarm expectations follow DIGITAL_CLOCK_ALARM_EN.
module tb_digital_clock_tk;

`ifdef DIGITAL_CLOCK_ALARM_EN
  localparam int ALARM = 1;
`else
  localparam int ALARM = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b1;
  logic       mode_12h = 1'b0;
  logic [4:0] hour_out;
  logic [5:0] min_out, sec_out;
  logic       pm, sec_tick, day_tick;
  logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;

  int checks = 0;
  int failures = 0;

  digital_clock_tk_if bus_if();

  digital_clock_tk #(
    .TICK_DIV(4), .INIT_HOUR(23), .INIT_MIN(59), .INIT_SEC(58)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode_12h(mode_12h), .bus(bus_if),
    .hour_out(hour_out), .min_out(min_out), .sec_out(sec_out), .pm(pm),
    .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
    .hr_1s(hr_1s), .hr_10s(hr_10s), .sec_tick(sec_tick), .day_tick(day_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] tp(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic do_load(input logic [16:0] t);
    bus_if.load_valid = 1'b1;
    bus_if.load_time  = t;
    @(negedge clk);
    bus_if.load_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_alarm(input logic on, input int exp_fires);
    int fires;
    run = 1'b0;
    bus_if.alarm_on = on;
    do_load(tp(7, 29, 59));
    run = 1'b1;
    fires = 0;
    repeat (6) begin
      @(negedge clk);
      fires += int'(bus_if.alarm_fire);
    end
    run = 1'b0;
    chk("alarm_fires", 32'(fires), 32'(exp_fires));
    chk("alarm_hhmm", 32'({hour_out, min_out}), 32'({5'd7, 6'd30}));
  endtask

  int hrs [4] = '{0, 11, 12, 13};
  int e10 [4] = '{1, 1, 1, 0};
  int e1  [4] = '{2, 1, 2, 1};
  int epm [4] = '{0, 0, 1, 1};

  initial begin
    int nsec, nday, k;
    bus_if.load_valid  = 1'b0;
    bus_if.load_time   = '0;
    bus_if.alarm_valid = 1'b0;
    bus_if.alarm_time  = '0;
    bus_if.alarm_on    = 1'b0;

    @(negedge clk);
    chk("rst_ready", 32'(bus_if.load_ready), 1);
    chk("rst_ticks", 32'({sec_tick, day_tick, bus_if.load_err, bus_if.alarm_fire}), 0);
    chk("rst_bcd", 32'({hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s}), 32'h235958);
    rst_n = 1'b1;

    nsec = 0; nday = 0;
    repeat (8) begin
      @(negedge clk);
      nsec += int'(sec_tick);
      nday += int'(day_tick);
    end
    chk("wrap_time", 32'({hour_out, min_out, sec_out}), 0);
    chk("wrap_day_tick", 32'(nday), 1);
    chk("wrap_sec_ticks", 32'(nsec), 2);

    // Load lands on the edge where the next tick is due.
    repeat (3) @(negedge clk);
    bus_if.load_valid = 1'b1;
    bus_if.load_time  = tp(13, 5, 7);
    @(negedge clk);
    bus_if.load_valid = 1'b0;
    chk("load_time", 32'({hour_out, min_out, sec_out}), 32'(tp(13, 5, 7)));
    chk("load_no_tick", 32'(sec_tick), 0);
    chk("load_busy", 32'(bus_if.load_ready), 0);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("load_ready_back", 32'(bus_if.load_ready), 1);
      if (sec_tick) break;
    end
    chk("load_next_tick", 32'(k), 4);
    chk("load_sec8", 32'(sec_out), 8);

    bus_if.load_valid = 1'b1;
    bus_if.load_time  = tp(24, 0, 0);
    @(negedge clk);
    bus_if.load_valid = 1'b0;
    chk("err_hour", 32'(bus_if.load_err), 1);
    chk("err_hour_time", 32'({hour_out, min_out, sec_out}), 32'(tp(13, 5, 8)));
    @(negedge clk);
    chk("err_pulse_end", 32'(bus_if.load_err), 0);
    bus_if.load_valid = 1'b1;
    bus_if.load_time  = tp(0, 60, 0);
    @(negedge clk);
    bus_if.load_valid = 1'b0;
    chk("err_min", 32'(bus_if.load_err), 1);
    chk("err_min_time", 32'({hour_out, min_out, sec_out}), 32'(tp(13, 5, 8)));
    @(negedge clk);

    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mode_12h = 1'b1;
      do_load(tp(hrs[i], 0, 0));
      chk("h12_digits", 32'({hr_10s, hr_1s}), 32'({4'(e10[i]), 4'(e1[i])}));
      chk("h12_pm", 32'(pm), 32'(epm[i]));
    end
    mode_12h = 1'b0;
    #1;
    chk("h24_digits", 32'({hr_10s, hr_1s}), 32'h13);

    bus_if.alarm_valid = 1'b1;
    bus_if.alarm_time  = {5'd24, 6'd0};
    @(negedge clk);
    bus_if.alarm_valid = 1'b0;
    chk("alarm_bad_err", 32'(bus_if.load_err), 32'(ALARM));
    bus_if.alarm_valid = 1'b1;
    bus_if.alarm_time  = {5'd7, 6'd30};
    @(negedge clk);
    bus_if.alarm_valid = 1'b0;
    run_alarm(1'b1, ALARM);
    run_alarm(1'b0, 0);

    do_load(tp(10, 20, 30));
    run = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    nsec = 0;
    repeat (10) begin
      @(negedge clk);
      nsec += int'(sec_tick);
    end
    chk("hold_time", 32'({hour_out, min_out, sec_out}), 32'(tp(10, 20, 30)));
    chk("hold_no_tick", 32'(nsec), 0);
    run = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    chk("resume_tick", 32'(sec_tick), 1);
    chk("resume_sec", 32'(sec_out), 31);

    bus_if.load_valid = 1'b1;
    bus_if.load_time  = tp(1, 2, 3);
    @(negedge clk);
    bus_if.load_valid = 1'b0;
    chk("busy_before_rst", 32'(bus_if.load_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_ready", 32'(bus_if.load_ready), 1);
    chk("rst_busy_time", 32'({hour_out, min_out, sec_out}), 32'(tp(23, 59, 58)));
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
